// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default constants for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK,
        PARITY
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one tick every BAUD_DIV clocks
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   clear  in   holds the divider at 0 and suppresses tick
//   tick   out  high for the cycle in which the divider equals BAUD_DIV-1
module uart_baud_tick #(
    parameter int BAUD_DIV = 54
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = !clear && (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 16x oversampled UART receiver: sync, start detect, mid-bit sampling
//
// Optional feature macro: UART_RX_PARITY_EN (adds even-parity bit and parity_err output)
//
// Ports:
//   clock                in   system clock
//   reset                in   asynchronous active-low reset
//   rx_in                in   raw serial line, idles high
//   rx_data              out  last good frame, LSB = first received bit
//   rx_valid             out  one-cycle pulse when rx_data updates
//   frame_err            out  one-cycle pulse when the stop bit is sampled low
//   rx_busy              out  high whenever the receiver is not idle
//   rx_bit_count_reg_en  out  one-cycle pulse per sampled data bit
//   parity_err           out  one-cycle pulse on parity mismatch (parity build only)
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 54,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 rx_bit_count_reg_en
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t              state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_prev;
    logic [SW-1:0]          samp_cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   tick;
    logic                   mid_bit;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad;
`endif

    // Divider is parked in IDLE so the first tick of a frame lands exactly
    // BAUD_DIV clocks after the start edge is seen.
    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    assign mid_bit = tick && (samp_cnt == SAMP_LAST);
    assign rx_busy = (state != IDLE);

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            samp_cnt            <= '0;
            bit_idx             <= '0;
            shreg               <= '0;
            rx_data             <= '0;
            rx_valid            <= 1'b0;
            frame_err           <= 1'b0;
            rx_bit_count_reg_en <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err          <= 1'b0;
            par_bad             <= 1'b0;
`endif
        end else begin
            rx_valid            <= 1'b0;
            frame_err           <= 1'b0;
            rx_bit_count_reg_en <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err          <= 1'b0;
`endif
            if (tick) begin
                samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SW'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s && rx_prev) begin
                        state    <= START;
                        samp_cnt <= '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in; a short low pulse is ignored.
                    if (tick && (samp_cnt == SAMP_HALF)) begin
                        if (!rx_s) begin
                            state    <= DATA;
                            samp_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shreg               <= {rx_s, shreg[DATA_BITS-1:1]};
                        rx_bit_count_reg_en <= 1'b1;
                        bit_idx             <= bit_idx + BW'(1);
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_bit) begin
                        par_bad <= (^shreg) ^ rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (mid_bit) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A held-low line must return high before a new start edge can exist.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- UART receive front end for an 8N1-style serial line.
- Synchronises the asynchronous rx line and detects the start bit using 16x oversampling.
- Samples each data bit at mid-bit and shifts it in LSB first, then checks the stop bit and presents the received byte.
- Directly upstream of the rx bit-count register: emits one rx_bit_count_reg_en pulse per sampled data bit, which feeds that counter.

Parameters:
- BAUD_DIV, 54, clocks per oversample tick (100 MHz / (115200 x 16) ≈ 54); legal range >= 2.
- OVERSAMPLE, 16, oversample ticks per bit; must be even, >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_in  in  1  raw serial line; asynchronous to clock; idles high.
- rx_data  out  DATA_BITS  last good byte, LSB = first received bit; held until the next good frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  out  1  high in any state other than IDLE.
- rx_bit_count_reg_en  out  1  one-cycle pulse per sampled data bit.

Behaviour:
- Reset (reset low, async):
  - All outputs 0; rx_data 0.
  - Synchroniser flops set to 1; FSM to IDLE; tick and sample counters 0.
- Synchroniser: two flops on rx_in; rx_s is the second-stage output. All line decisions use rx_s.
- Tick generator:
  - Counter runs 0..BAUD_DIV-1.
  - tick = 1 for the cycle in which the counter equals BAUD_DIV-1; counter wraps to 0 on that cycle.
  - Counter held at 0 in IDLE.
- Sample counter: 0..OVERSAMPLE-1; advances on tick.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s high->low edge (rx_s=0 and previous rx_s=1) -> START; clear tick counter and sample counter.
- START:
  - On the tick where sample count = OVERSAMPLE/2-1 (mid start bit): if rx_s=0 -> DATA, clear sample count, bit index = 0; else -> IDLE (glitch rejected, no outputs).
- DATA:
  - On the tick where sample count = OVERSAMPLE-1: shift register <= {rx_s, shreg[DATA_BITS-1:1]}.
  - rx_bit_count_reg_en = 1 for that single cycle; bit index increments.
  - After DATA_BITS samples -> STOP (or PARITY when the optional feature is compiled in).
- STOP:
  - On the tick where sample count = OVERSAMPLE-1:
    - rx_s=1 -> rx_data <= shreg, rx_valid pulse, -> IDLE.
    - rx_s=0 -> frame_err pulse, rx_data unchanged, -> BREAK.
- BREAK: wait for rx_s=1, then -> IDLE.
- Latency: rx_valid / frame_err assert in the clock following the stop-bit mid-sample tick.
- No backpressure: a consumer that misses rx_valid loses nothing except the pulse; rx_data is still held.
- Back-to-back frames: a start edge is accepted on the first IDLE cycle after STOP.
- Reset mid-frame: the frame is discarded; no rx_valid.
- Counter widths: $clog2 of the respective range; no overflow is possible.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds state PARITY between DATA and STOP and output port parity_err (out, 1).
  - The parity bit is sampled like a data bit but does not pulse rx_bit_count_reg_en.
  - Even parity: if XOR(data bits, parity bit) = 1, the frame is treated as errored:
    - parity_err pulses in the same cycle rx_valid would have.
    - rx_valid is suppressed; rx_data is unchanged.
  - parity_err resets to 0.
- When undefined: no PARITY state, no parity_err port; frame = start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK, PARITY}.
  - Default constants UART_OVERSAMPLE=16, UART_DATA_BITS=8.
- Sub-module uart_baud_tick: tick generator with BAUD_DIV parameter and a clear input.
  - Reusable by the tx side.
- Synchroniser, FSM and shift register stay in uart_rx_frontend.

Test Plan (BAUD_DIV=4, OVERSAMPLE=16 -> 64 clocks/bit):
- Send frame 0xA5 (LSB first, stop=1) -> exactly 8 rx_bit_count_reg_en pulses, 64 clocks apart; then rx_valid one cycle with rx_data=8'hA5, frame_err=0, rx_busy falls.
- Send 0x3C then 0xFF with no idle gap -> two rx_valid pulses, rx_data 8'h3C then 8'hFF.
- Pull rx_in low for 20 clocks, then high -> START then IDLE; no rx_valid, no rx_bit_count_reg_en, rx_busy returns 0.
- Send 0x55 with stop bit 0, then hold low 200 clocks, then high -> one frame_err pulse; rx_data keeps its prior value; FSM stays in BREAK until the line goes high; the next 0x12 frame is received correctly.
- Assert reset low mid-DATA (after 3 bits), release, send 0x81 -> no output from the aborted frame; rx_data=8'h81 after the next frame.
- UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_valid, 8'h07; 0x07 with parity 0 -> parity_err pulse, no rx_valid.
